// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, command kinds, FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int ALU_OP_W  = 3;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        KIND_LOAD = 2'b00,
        KIND_EXEC = 2'b01,
        KIND_PEEK = 2'b10,
        KIND_CLRF = 2'b11
    } cmd_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    // 010 and 011 are holes in the ALU opcode map.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return !((op == 3'b010) || (op == 3'b011));
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_alu.sv
// Combinational 4-bit ALU that the sequencer drives; instanced beside the sequencer, not inside it.
module alu_cmd_sequencer_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP_W  = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Handshaked command front end for the ALU: owns the accumulator and operand registers,
// issues one operation per accepted command and returns a single response.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic             ovf_sticky,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [OP_W-1:0]  alu_op_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_ovf_q, rsp_err_q, ovf_sticky_q;
    logic             accept;
    logic             legal_exec;

    assign accept     = cmd_valid && cmd_ready;
    assign legal_exec = (cmd_kind == KIND_EXEC) && is_legal_op(cmd_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = legal_exec ? ST_ISSUE : ST_RESP;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Ready is gated by rst_n so the host sees no acceptance window while reset is held.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && rst_n;
        rsp_valid = (state_q == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_data_q   <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rsp_ovf_q <= 1'b0;
                        rsp_err_q <= 1'b0;
                        case (cmd_kind)
                            KIND_LOAD: begin
                                acc_q      <= cmd_data;
                                rsp_data_q <= cmd_data;
                            end
                            KIND_PEEK: rsp_data_q <= acc_q;
                            KIND_CLRF: begin
                                ovf_sticky_q <= 1'b0;
                                rsp_data_q   <= acc_q;
                            end
                            default: begin
                                // Illegal opcodes leave the ALU inputs untouched.
                                if (legal_exec) begin
                                    alu_a_q  <= acc_q;
                                    alu_b_q  <= cmd_data;
                                    alu_op_q <= cmd_op;
                                end else begin
                                    rsp_data_q <= acc_q;
                                    rsp_err_q  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_CAPTURE: begin
                    acc_q        <= alu_result;
                    rsp_data_q   <= alu_result;
                    rsp_ovf_q    <= alu_overflow;
                    ovf_sticky_q <= ovf_sticky_q | alu_overflow;
                end
                default: ;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: sequencer plus ALU, hand-computed responses, latencies and stall/reset behaviour.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_kind;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_ovf, rsp_err, ovf_sticky;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_overflow;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    alu_cmd_sequencer #(.WIDTH(4), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .ovf_sticky(ovf_sticky),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow)
    );

    alu_cmd_sequencer_alu #(.WIDTH(4), .OP_W(3)) u_alu (
        .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result), .overflow(alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a command, waits for acceptance, and counts cycles until rsp_valid.
    task automatic issue(input logic [1:0] kind, input logic [2:0] op, input logic [3:0] data,
                         output int lat);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = kind; cmd_op = op; cmd_data = data;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("accept_timeout", 8'd0, 8'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
        if (lat >= 50) chk("rsp_timeout", 8'd0, 8'd1);
    endtask

    task automatic take(input string tag, input logic [3:0] d, input logic o, input logic e);
        chk({tag, "_data"}, {4'h0, rsp_data}, {4'h0, d});
        chk({tag, "_ovf"},  {7'h0, rsp_ovf},  {7'h0, o});
        chk({tag, "_err"},  {7'h0, rsp_err},  {7'h0, e});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] kind, input logic [2:0] op,
                       input logic [3:0] data, input int exp_lat,
                       input logic [3:0] d, input logic o, input logic e);
        int lat;
        issue(kind, op, data, lat);
        chk({tag, "_lat"}, lat[7:0], exp_lat[7:0]);
        take(tag, d, o, e);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_kind = '0; cmd_op = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_ready", {7'h0, cmd_ready}, 8'h00);
        chk("rst_valid", {7'h0, rsp_valid}, 8'h00);
        chk("rst_outs",  {alu_a, rsp_data}, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {7'h0, cmd_ready}, 8'h01);

        run("load_a",  KIND_LOAD, 3'b000, 4'b1010, 1, 4'b1010, 1'b0, 1'b0);
        run("add",     KIND_EXEC, OP_ADD, 4'b0100, 3, 4'b1110, 1'b0, 1'b0);
        chk("add_alu", {alu_a, alu_b}, 8'b1010_0100);
        chk("add_op",  {5'h0, alu_op}, {5'h0, OP_ADD});
        run("peek",    KIND_PEEK, 3'b000, 4'b0000, 1, 4'b1110, 1'b0, 1'b0);

        run("load_b",  KIND_LOAD, 3'b000, 4'b1010, 1, 4'b1010, 1'b0, 1'b0);
        run("sub",     KIND_EXEC, OP_SUB, 4'b0100, 3, 4'b0110, 1'b1, 1'b0);
        chk("sticky_set", {7'h0, ovf_sticky}, 8'h01);
        run("peek_s",  KIND_PEEK, 3'b000, 4'b0000, 1, 4'b0110, 1'b0, 1'b0);
        chk("sticky_hold", {7'h0, ovf_sticky}, 8'h01);
        run("clrf",    KIND_CLRF, 3'b000, 4'b0000, 1, 4'b0110, 1'b0, 1'b0);
        chk("sticky_clr", {7'h0, ovf_sticky}, 8'h00);

        run("ld_and",  KIND_LOAD, 3'b000, 4'b0101, 1, 4'b0101, 1'b0, 1'b0);
        run("and",     KIND_EXEC, OP_AND, 4'b1011, 3, 4'b0001, 1'b0, 1'b0);
        run("ld_or",   KIND_LOAD, 3'b000, 4'b0101, 1, 4'b0101, 1'b0, 1'b0);
        run("or",      KIND_EXEC, OP_OR,  4'b1011, 3, 4'b1111, 1'b0, 1'b0);
        run("ld_xor",  KIND_LOAD, 3'b000, 4'b0101, 1, 4'b0101, 1'b0, 1'b0);
        run("xor",     KIND_EXEC, OP_XOR, 4'b1011, 3, 4'b1110, 1'b0, 1'b0);
        run("ld_not",  KIND_LOAD, 3'b000, 4'b0101, 1, 4'b0101, 1'b0, 1'b0);
        run("not",     KIND_EXEC, OP_NOT, 4'b0000, 3, 4'b1010, 1'b0, 1'b0);
        chk("sticky_logic", {7'h0, ovf_sticky}, 8'h00);

        // Illegal opcode: error response, accumulator and ALU drive untouched.
        run("illegal", KIND_EXEC, 3'b010, 4'b1111, 1, 4'b1010, 1'b0, 1'b1);
        chk("ill_alu", {alu_a, alu_b}, 8'b0101_0000);
        chk("ill_op",  {5'h0, alu_op}, {5'h0, OP_NOT});
        run("ill_peek", KIND_PEEK, 3'b000, 4'b0000, 1, 4'b1010, 1'b0, 1'b0);

        // Wrap: 0111 + 0001 overflows to 1000.
        run("ld_w",    KIND_LOAD, 3'b000, 4'b0111, 1, 4'b0111, 1'b0, 1'b0);
        run("wrap",    KIND_EXEC, OP_ADD, 4'b0001, 3, 4'b1000, 1'b1, 1'b0);
        run("clrf2",   KIND_CLRF, 3'b000, 4'b0000, 1, 4'b1000, 1'b0, 1'b0);

        // Backpressure: hold rsp_ready low with a second command waiting.
        issue(KIND_EXEC, OP_ADD, 4'b0011, lat);
        chk("stall_lat", lat[7:0], 8'd3);
        cmd_valid = 1'b1; cmd_kind = KIND_LOAD; cmd_data = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {7'h0, rsp_valid}, 8'h01);
            chk("stall_data",  {4'h0, rsp_data},  8'h0b);
            chk("stall_ready", {7'h0, cmd_ready}, 8'h00);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("queued_valid", {7'h0, rsp_valid}, 8'h01);
        take("queued", 4'b0000, 1'b0, 1'b0);

        // Reset while the ALU operation is in ISSUE.
        run("ld_r", KIND_LOAD, 3'b000, 4'b0011, 1, 4'b0011, 1'b0, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = KIND_EXEC; cmd_op = OP_ADD; cmd_data = 4'b0001;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("pre_rst_alu", {alu_a, alu_b}, 8'b0011_0001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu",  {alu_a, alu_b}, 8'h00);
        chk("mid_rst_misc", {rsp_valid, cmd_ready, rsp_ovf, rsp_err, ovf_sticky, alu_op}, 8'h00);
        chk("mid_rst_data", {4'h0, rsp_data}, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_norsp", {7'h0, rsp_valid}, 8'h00);
        end
        run("post_peek", KIND_PEEK, 3'b000, 4'b0000, 1, 4'b0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-driven front end that owns the operand/opcode side of the 4-bit ALU interface and consumes its result/overflow side. Holds an accumulator, issues one ALU operation per accepted command, registers result and overflow, and returns a response over a valid/ready channel. Sits between a host controller (or bench) and a combinational ALU instance; replaces hand-driven a/b/op stimulus with a clocked, handshaked path.

Parameters:
WIDTH, 4, operand/result width
OP_W, 3, ALU opcode width

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_kind  in  2  00 LOAD, 01 EXEC, 10 PEEK, 11 CLRF
cmd_op  in  OP_W  ALU opcode (EXEC only)
cmd_data  in  WIDTH  load value or operand b
rsp_valid  out  1  response present
rsp_ready  in  1  host takes response
rsp_data  out  WIDTH  result / accumulator value
rsp_ovf  out  1  overflow of this EXEC
rsp_err  out  1  illegal opcode rejected
ovf_sticky  out  1  OR of all EXEC overflows since reset/CLRF
alu_a  out  WIDTH  to ALU operand a
alu_b  out  WIDTH  to ALU operand b
alu_op  out  OP_W  to ALU opcode
alu_result  in  WIDTH  from ALU
alu_overflow  in  1  from ALU

Behaviour:
- Reset (rst_n low, async): state IDLE; acc, alu_a, alu_b, alu_op, rsp_data = 0; rsp_valid, rsp_ovf, rsp_err, ovf_sticky = 0; cmd_ready = 0 while in reset, 1 in first IDLE cycle after release. Reset mid-operation discards in-flight command and pending response.
- Opcode encoding (ALU contract): 000 ADD, 001 SUB, 100 AND, 101 OR, 110 XOR, 111 NOT a. 010/011 illegal. Overflow = signed two's-complement overflow for ADD/SUB, 0 for logic ops.
- FSM: IDLE -> (cmd_valid & cmd_ready) -> decode:
  - LOAD: acc <= cmd_data; -> RESP with rsp_data=cmd_data, ovf=0, err=0.
  - PEEK: -> RESP with rsp_data=acc, ovf=0, err=0.
  - CLRF: ovf_sticky <= 0; -> RESP with rsp_data=acc.
  - EXEC legal: alu_a<=acc, alu_b<=cmd_data, alu_op<=cmd_op; -> ISSUE.
  - EXEC illegal: no ALU drive change, acc unchanged; -> RESP err=1, rsp_data=acc.
- ISSUE (1 cycle, ALU settles on registered operands) -> CAPTURE.
- CAPTURE: acc <= alu_result; rsp_data <= alu_result; rsp_ovf <= alu_overflow; ovf_sticky <= ovf_sticky | alu_overflow; -> RESP.
- RESP: rsp_valid=1, outputs stable until rsp_valid & rsp_ready; then -> IDLE. cmd_ready=1 only in IDLE. rsp_ready may be high early; no effect outside RESP.
- Latency, handshake to rsp_valid: LOAD/PEEK/CLRF/illegal 1 cycle; EXEC 3 cycles. Throughput: one command in flight.
- alu_a/alu_b/alu_op hold last issued values between commands (ALU inputs never glitch while idle).
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- cmd_valid deasserted before acceptance: no effect. Unknown cmd_kind impossible (2-bit fully decoded).

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_NOT), cmd_kind constants, FSM state encoding (IDLE, ISSUE, CAPTURE, RESP), function is_legal_op.
- Single module; ALU instanced outside. Bench instantiates alu_cmd_sequencer plus the ALU on the alu_* ports.

Test Plan:
- Reset then LOAD 1010, EXEC ADD 0100 -> rsp_data 1110, rsp_ovf 0, 3 cycles after accept; PEEK -> 1110.
- LOAD 1010, EXEC SUB 0100 -> rsp_data 0110, rsp_ovf 1, ovf_sticky 1; CLRF -> ovf_sticky 0.
- LOAD 0101, EXEC AND/OR/XOR 1011 in turn (reload between) -> 0001, 1111, 1110; ovf 0 each; EXEC NOT -> 1010.
- EXEC opcode 010 -> rsp_err 1, acc unchanged, alu_* outputs unchanged.
- rsp_ready held low 5 cycles after EXEC result -> rsp_valid/rsp_data stable, cmd_ready 0, second cmd_valid not accepted until response taken.
- Assert rst_n low during ISSUE -> all outputs 0 immediately, acc 0, no response delivered after release.
